// File: rtl/lcd_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : lcd_display_scan
// Purpose  : Walks display slots 1..NUM_SLOTS once per frame, queries a client
//            for each slot, compares the answer against a per-slot shadow copy
//            and pushes render entries downstream only for slots that changed
//            (or for every slot when the shadow is stale or the frame is forced).
// Ports    : clk, resetn (sync, active-low)
//            scan_enable, force_refresh          - frame control
//            display_number / display_valid,
//            display_name, display_value         - client query/response
//            entry_valid/ready, entry_index,
//            entry_name, entry_value, entry_blank- downstream render entry
//            frame_done                          - end-of-frame pulse
// Revision : 1.0 - initial release
// ============================================================================
module lcd_display_scan #(
  parameter int NUM_SLOTS = 44,
  parameter int SETTLE    = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        scan_enable,
  input  logic        force_refresh,
  output logic [5:0]  display_number,
  input  logic        display_valid,
  input  logic [39:0] display_name,
  input  logic [31:0] display_value,
  output logic        entry_valid,
  input  logic        entry_ready,
  output logic [5:0]  entry_index,
  output logic [39:0] entry_name,
  output logic [31:0] entry_value,
  output logic        entry_blank,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_CMP  = 3'd3,
    S_PUSH = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [5:0] LAST_IDX  = 6'(NUM_SLOTS);
  // WAIT holds SETTLE cycles; the counter counts down to zero inclusive.
  localparam logic [1:0] WAIT_INIT = 2'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t       state_q;
  logic [5:0]   idx_q;
  logic [1:0]   wait_q;
  logic         pending_q;   // force_refresh seen, waiting for next frame
  logic         forced_q;    // current frame pushes every slot
  logic [NUM_SLOTS-1:0] stale_q;

  logic [5:0]   display_number_q;
  logic         entry_valid_q;
  logic [5:0]   entry_index_q;
  logic [39:0]  entry_name_q;
  logic [31:0]  entry_value_q;
  logic         entry_blank_q;
  logic         frame_done_q;

  logic         samp_valid_q;
  logic [39:0]  samp_name_q;
  logic [31:0]  samp_value_q;

  logic         sh_valid_q [NUM_SLOTS];
  logic [39:0]  sh_name_q  [NUM_SLOTS];
  logic [31:0]  sh_value_q [NUM_SLOTS];

  logic [5:0]   slot_sel;
  logic         differs;
  logic         push_hit;
  logic         xfer;

  assign slot_sel = idx_q - 6'd1;

  // Name/value only matter for a valid slot; an invalid slot that stays
  // invalid is unchanged regardless of what the client leaves on the bus.
  assign differs  = (display_valid != sh_valid_q[slot_sel]) ||
                    (display_valid && ((display_name  != sh_name_q[slot_sel]) ||
                                       (display_value != sh_value_q[slot_sel])));
  assign push_hit = differs || stale_q[slot_sel] || forced_q;
  assign xfer     = (state_q == S_PUSH) && entry_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      idx_q            <= 6'd0;
      wait_q           <= 2'd0;
      pending_q        <= 1'b0;
      forced_q         <= 1'b0;
      stale_q          <= '1;
      display_number_q <= 6'd0;
      entry_valid_q    <= 1'b0;
      entry_index_q    <= 6'd0;
      entry_name_q     <= 40'd0;
      entry_value_q    <= 32'd0;
      entry_blank_q    <= 1'b0;
      frame_done_q     <= 1'b0;
      samp_valid_q     <= 1'b0;
      samp_name_q      <= 40'd0;
      samp_value_q     <= 32'd0;
    end else begin
      frame_done_q <= 1'b0;
      if (force_refresh) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          display_number_q <= 6'd0;
          if (scan_enable) begin
            idx_q     <= 6'd1;
            forced_q  <= pending_q | force_refresh;
            pending_q <= 1'b0;
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          display_number_q <= idx_q;
          wait_q           <= WAIT_INIT;
          state_q          <= (SETTLE == 0) ? S_CMP : S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == 2'd0) begin
            state_q <= S_CMP;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        S_CMP: begin
          samp_valid_q <= display_valid;
          samp_name_q  <= display_name;
          samp_value_q <= display_value;
          if (push_hit) begin
            entry_valid_q <= 1'b1;
            entry_index_q <= idx_q;
            entry_blank_q <= ~display_valid;
            entry_name_q  <= display_valid ? display_name  : 40'd0;
            entry_value_q <= display_valid ? display_value : 32'd0;
            state_q       <= S_PUSH;
          end else if (idx_q == LAST_IDX) begin
            frame_done_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            idx_q   <= idx_q + 6'd1;
            state_q <= S_ADDR;
          end
        end
        S_PUSH: begin
          if (entry_ready) begin
            entry_valid_q     <= 1'b0;
            stale_q[slot_sel] <= 1'b0;
            if (idx_q == LAST_IDX) begin
              frame_done_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              idx_q   <= idx_q + 6'd1;
              state_q <= S_ADDR;
            end
          end
        end
        S_DONE: begin
          display_number_q <= 6'd0;
          forced_q         <= 1'b0;
          state_q          <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Shadow copy is updated only when the downstream actually takes the entry.
  always_ff @(posedge clk) begin
    if (resetn && xfer) begin
      sh_valid_q[slot_sel] <= samp_valid_q;
      sh_name_q[slot_sel]  <= samp_name_q;
      sh_value_q[slot_sel] <= samp_value_q;
    end
  end

  assign display_number = display_number_q;
  assign entry_valid    = entry_valid_q;
  assign entry_index    = entry_index_q;
  assign entry_name     = entry_name_q;
  assign entry_value    = entry_value_q;
  assign entry_blank    = entry_blank_q;
  assign frame_done     = frame_done_q;

endmodule
`default_nettype wire
